// File: rtl/regfile_writeback_if.sv
// Purpose: result handshake from execute into the writeback queue.
// Latency: none, this is wiring only.
// Backpressure: in_ready low means the offered result is not taken this cycle.
// Ports: in_valid/in_rd/in_data are driven by execute (master).
//        in_ready is driven by the writeback block (slave).
interface regfile_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rd;
  logic [31:0] in_data;

  modport master (output in_valid, output in_rd, output in_data, input in_ready);
  modport slave  (input in_valid, input in_rd, input in_data, output in_ready);
endinterface

// File: rtl/regfile_writeback.sv
// Purpose: queues execute results and feeds them to the register file write port, with operand forwarding.
// Latency: a result pushed into an empty, unstalled queue shows up as wb_we one edge later.
// Backpressure: in_ready drops when DEPTH entries are queued; wb_stall freezes draining.
// Ports: clk/rst_n        clock, async active-low reset
//        push (slave)      in_valid/in_ready/in_rd/in_data from execute
//        wb_stall          register file write port busy this cycle
//        wb_we/wb_rd/wb_data  registered register file write port
//        q_rs1/q_rs2       decoder source indices; hit_rsX/fwd_rsX give the youngest pending value
//        count             queue occupancy; the output stage is not counted
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  regfile_writeback_if.slave       push,
  input  logic                     wb_stall,
  output logic                     wb_we,
  output logic [3:0]               wb_rd,
  output logic [31:0]              wb_data,
  input  logic [3:0]               q_rs1,
  input  logic [3:0]               q_rs2,
  output logic                     hit_rs1,
  output logic                     hit_rs2,
  output logic [31:0]              fwd_rs1,
  output logic [31:0]              fwd_rs2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // No look-ahead on a same-cycle pop: a full queue refuses even if it drains now.
  assign push.in_ready = (count < CW'(DEPTH));

  // Writes to r0 are handshaken so execute is not blocked, but are dropped here.
  assign do_push = push.in_valid && push.in_ready && (push.in_rd != 4'd0);
  assign do_pop  = !wb_stall && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      vld     <= '0;
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      // Pop clears before push sets; the indices can only coincide when the
      // queue is empty (no pop) or full (no push), so the order never matters.
      if (do_pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + AW'(1);
        wb_rd       <= mem[rd_ptr].rd;
        wb_data     <= mem[rd_ptr].data;
      end
      if (do_push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      wb_we <= do_pop;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry payloads need no reset: the valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= '{rd: push.in_rd, data: push.in_data};
    end
  end

  // Start from the output stage (oldest), then walk the queue oldest to
  // youngest so the last match found is the youngest pending value.
  function automatic logic [32:0] lookup(input logic [3:0] q);
    logic          hit;
    logic [31:0]   val;
    logic [AW-1:0] idx;
    hit = 1'b0;
    val = '0;
    if (q != 4'd0) begin
      if (wb_we && (wb_rd == q)) begin
        hit = 1'b1;
        val = wb_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + AW'(i);
        if (vld[idx] && (mem[idx].rd == q)) begin
          hit = 1'b1;
          val = mem[idx].data;
        end
      end
    end
    return {hit, val};
  endfunction

  always_comb begin
    {hit_rs1, fwd_rs1} = lookup(q_rs1);
    {hit_rs2, fwd_rs2} = lookup(q_rs2);
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Purpose: directed checks of the writeback queue against hand-computed values.
// Latency: inputs change 1 ns after a rising edge, outputs are sampled there too.
// Backpressure: stall and full-queue behaviour are exercised explicitly.
module tb_regfile_writeback;

  logic        clk;
  logic        rst_n;
  logic        wb_stall;
  logic        wb_we;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [3:0]  q_rs1;
  logic [3:0]  q_rs2;
  logic        hit_rs1;
  logic        hit_rs2;
  logic [31:0] fwd_rs1;
  logic [31:0] fwd_rs2;
  logic [2:0]  count;

  int          vectors;
  int          errors;
  int          we_count;
  int          we_base;
  logic [31:0] rf [16];

  regfile_writeback_if in_if ();

  regfile_writeback #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (in_if),
    .wb_stall (wb_stall),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .q_rs1    (q_rs1),
    .q_rs2    (q_rs2),
    .hit_rs1  (hit_rs1),
    .hit_rs2  (hit_rs2),
    .fwd_rs1  (fwd_rs1),
    .fwd_rs2  (fwd_rs2),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model plus a tally of committed writes.
  initial we_count = 0;
  always @(posedge clk) begin
    if (wb_we) begin
      rf[wb_rd] <= wb_data;
      we_count  <= we_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [3:0] rd, input logic [31:0] d);
    in_if.in_valid = v;
    in_if.in_rd    = rd;
    in_if.in_data  = d;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    for (int r = 0; r < 16; r++) rf[r] = 32'hdead_beef;
    rst_n    = 1'b0;
    wb_stall = 1'b0;
    q_rs1    = 4'd0;
    q_rs2    = 4'd0;
    offer(1'b0, 4'd0, 32'd0);

    // Reset state
    #1;
    chk("rst_wb_we", wb_we, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_if.in_ready, 1);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    q_rs1 = 4'd3;
    #1;
    chk("rst_hit_rs1", hit_rs1, 0);
    chk("rst_hit_rs2", hit_rs2, 0);
    q_rs1 = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Two back-to-back results drain on consecutive cycles
    offer(1'b1, 4'd3, 32'd45);
    step();
    chk("t1_lat_we", wb_we, 0);
    chk("t1_lat_count", count, 1);
    offer(1'b1, 4'd5, 32'd77);
    step();
    offer(1'b0, 4'd0, 32'd0);
    chk("t1_we0", wb_we, 1);
    chk("t1_rd0", wb_rd, 3);
    chk("t1_data0", wb_data, 45);
    step();
    chk("t1_we1", wb_we, 1);
    chk("t1_rd1", wb_rd, 5);
    chk("t1_data1", wb_data, 77);
    chk("t1_count", count, 0);
    step();
    chk("t1_we_idle", wb_we, 0);
    chk("t1_rf3", rf[3], 45);
    chk("t1_rf5", rf[5], 77);

    // Stall fills the queue; a fifth offer is refused; release drains in order
    wb_stall = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      offer(1'b1, 4'(k), 32'(16 * k));
      step();
    end
    chk("t2_count_full", count, 4);
    chk("t2_in_ready", in_if.in_ready, 0);
    chk("t2_we_stalled", wb_we, 0);
    chk("t2_rd_hold", wb_rd, 5);
    chk("t2_data_hold", wb_data, 77);
    offer(1'b1, 4'd6, 32'h66);
    step();
    chk("t2_count_5th", count, 4);
    offer(1'b0, 4'd0, 32'd0);
    we_base  = we_count;
    wb_stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t2_drain_we", wb_we, 1);
      chk("t2_drain_rd", wb_rd, 32'(k));
      chk("t2_drain_data", wb_data, 32'(16 * k));
    end
    chk("t2_count_empty", count, 0);
    chk("t2_ready_empty", in_if.in_ready, 1);
    step();
    chk("t2_we_after", wb_we, 0);
    chk("t2_write_total", we_count - we_base, 4);
    chk("t2_rf6_untouched", rf[6], 32'hdead_beef);

    // Forwarding: youngest queue entry wins, then the output stage
    wb_stall = 1'b1;
    offer(1'b1, 4'd7, 32'd1);
    step();
    offer(1'b1, 4'd7, 32'd2);
    step();
    offer(1'b0, 4'd0, 32'd0);
    q_rs1 = 4'd7;
    q_rs2 = 4'd4;
    #1;
    chk("t3_hit1", hit_rs1, 1);
    chk("t3_fwd1", fwd_rs1, 2);
    chk("t3_hit2", hit_rs2, 0);
    chk("t3_fwd2", fwd_rs2, 0);
    wb_stall = 1'b0;
    step();
    chk("t3_partial_fwd1", fwd_rs1, 2);
    step();
    chk("t3_stage_hit1", hit_rs1, 1);
    chk("t3_stage_fwd1", fwd_rs1, 2);
    step();
    chk("t3_idle_hit1", hit_rs1, 0);
    chk("t3_idle_fwd1", fwd_rs1, 0);

    // A write to r0 is swallowed
    we_base = we_count;
    offer(1'b1, 4'd0, 32'd99);
    step();
    offer(1'b0, 4'd0, 32'd0);
    chk("t4_count", count, 0);
    q_rs1 = 4'd0;
    #1;
    chk("t4_hit_r0", hit_rs1, 0);
    step();
    step();
    chk("t4_no_write", we_count - we_base, 0);

    // Simultaneous push and pop at count 2
    wb_stall = 1'b1;
    offer(1'b1, 4'd8, 32'h80);
    step();
    offer(1'b1, 4'd9, 32'h90);
    step();
    chk("t5_count_pre", count, 2);
    wb_stall = 1'b0;
    offer(1'b1, 4'd10, 32'ha0);
    step();
    offer(1'b0, 4'd0, 32'd0);
    chk("t5_count_same", count, 2);
    chk("t5_rd0", wb_rd, 8);
    step();
    chk("t5_rd1", wb_rd, 9);
    step();
    chk("t5_rd2", wb_rd, 10);
    chk("t5_data2", wb_data, 32'ha0);
    chk("t5_count_end", count, 0);
    step();

    // Reset mid-flight with three entries pending and wb_we high
    wb_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      offer(1'b1, 4'(11 + k), 32'(256 + k));
      step();
    end
    offer(1'b0, 4'd0, 32'd0);
    wb_stall = 1'b0;
    step();
    wb_stall = 1'b1;
    chk("t6_pre_we", wb_we, 1);
    chk("t6_pre_count", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_we", wb_we, 0);
    chk("t6_async_count", count, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    we_base  = we_count;
    wb_stall = 1'b0;
    repeat (4) step();
    chk("t6_no_write", we_count - we_base, 0);
    chk("t6_count_after", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of pending-result queue entries (power of two).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, a result is offered by execute.
REQ-005 The block SHALL have port in_ready, output, 1, the block can accept a result this cycle.
REQ-006 The block SHALL have port in_rd, input, 4, the destination register index of the offered result.
REQ-007 The block SHALL have port in_data, input, 32, the offered result value.
REQ-008 The block SHALL have port wb_stall, input, 1, the register file write port is unavailable this cycle.
REQ-009 The block SHALL have port wb_we, output, 1, which drives the register file reg_write.
REQ-010 The block SHALL have port wb_rd, output, 4, which drives the register file rd.
REQ-011 The block SHALL have port wb_data, output, 32, which drives the register file write_data.
REQ-012 The block SHALL have ports q_rs1 and q_rs2, input, 4 each, the decoder source-register indices to look up.
REQ-013 The block SHALL have ports hit_rs1 and hit_rs2, output, 1 each, flagging that a pending write to that source register exists.
REQ-014 The block SHALL have ports fwd_rs1 and fwd_rs2, output, 32 each, carrying the youngest pending value for that source register.
REQ-015 The block SHALL have port count, output, clog2(DEPTH)+1 bits, the queue occupancy.

Function
REQ-016 The block SHALL hold accepted results in a FIFO of DEPTH entries, with read and write pointers that wrap modulo DEPTH.
REQ-017 The block SHALL drive in_ready = (count < DEPTH) combinationally, with no look-ahead on a same-cycle pop.
REQ-018 A push SHALL occur on any edge where in_valid && in_ready holds.
REQ-019 A push with in_rd == 0 SHALL be accepted and discarded: no entry is stored, count is unchanged, and no wb_we is ever produced for it.
REQ-020 A pop SHALL occur on any edge where wb_stall == 0 and the pre-edge count > 0.
REQ-021 On a pop, the head entry SHALL be loaded into the wb_rd/wb_data output stage and wb_we SHALL be registered to 1; on edges with no pop, wb_we SHALL be 0.
REQ-022 Latency SHALL be as follows: a result pushed at edge N into an empty queue with no stall has wb_we high during the cycle after edge N+1.
REQ-023 On a simultaneous push and pop, both SHALL take effect and count SHALL be unchanged; entries SHALL drain in strict push order, one per cycle at most.
REQ-024 When wb_stall is held high, the queue SHALL retain all entries, wb_we SHALL be 0, and wb_rd/wb_data SHALL hold their last values.
REQ-025 hit_rsX SHALL be 1 when q_rsX != 0 and it matches any valid queue entry or the output stage while wb_we == 1.
REQ-026 fwd_rsX SHALL be the matching value with priority: youngest queue entry first, then the output stage; fwd_rsX SHALL be 0 when there is no hit.
REQ-027 q_rsX == 0 SHALL never hit.
REQ-028 count SHALL exclude the output stage.

Reset
REQ-029 While rst_n == 0, the block SHALL asynchronously clear: wb_we = 0, wb_rd = 0, wb_data = 0, pointers = 0, count = 0, all entries invalid, and hence hit_rs1 = hit_rs2 = 0 and in_ready = 1.
REQ-030 Reset asserted mid-operation SHALL discard all pending results, and no wb_we SHALL occur for them after release.

Verification
REQ-031 Push (rd=3, data=45) then (rd=5, data=77) on consecutive edges with no stall -> wb_we pulses on two consecutive cycles with (3, 45) then (5, 77); the register file then reads r3 = 45 and r5 = 77.
REQ-032 Hold wb_stall = 1 and push 4 results -> count = 4, in_ready = 0, and a 5th in_valid is not accepted; release the stall -> 4 in-order writes on 4 consecutive cycles, then count = 0 and in_ready = 1.
REQ-033 With wb_stall = 1, push (7, 1) then (7, 2) and set q_rs1 = 7, q_rs2 = 4 -> hit_rs1 = 1, fwd_rs1 = 2, hit_rs2 = 0, fwd_rs2 = 0.
REQ-034 Push (rd=0, data=99) -> count stays 0, no wb_we is produced, and q_rs1 = 0 gives hit_rs1 = 0.
REQ-035 At count = 2 with no stall, push and pop on the same edge -> count stays 2 and write order is preserved.
REQ-036 Assert rst_n = 0 with 3 entries pending and wb_we = 1 -> wb_we drops immediately without waiting for a clock edge, count = 0, and no writes occur after release.
